// File: rtl/fma_pkg.sv
// Shared types and widths for the fma datapath.
// Multiplier and adder request/response bundles.
package fma_pkg;

  localparam int MUL_W  = 27;
  localparam int PROD_W = 2 * MUL_W;
  localparam int CMD_W  = 32;

  typedef logic [CMD_W-1:0] cmd_t;

  typedef struct packed {
    logic             en;
    cmd_t             req_command;
    logic [MUL_W-1:0] req_in_1;
    logic [MUL_W-1:0] req_in_2;
  } mulit;

  typedef struct packed {
    logic [PROD_W-1:0] out;
  } mulot;

  typedef struct packed {
    logic              en;
    cmd_t              req_command;
    logic [PROD_W-1:0] req_in_1;
    logic [PROD_W-1:0] req_in_2;
  } addit;

  typedef struct packed {
    logic [PROD_W:0] out;
  } addot;

  // Low-half width of the multiplier operand split
  function automatic int split_w(input int w);
    return (w + 1) / 2;
  endfunction

endpackage

// File: rtl/mul_resp_pp.sv
// Split partial-product generator for the mantissa multiplier.
// b is cut into a low and a high slice, each multiplied by a.
module mul_resp_pp
  import fma_pkg::*;
#(
  parameter  int MUL_W = fma_pkg::MUL_W,
  localparam int SPLIT = split_w(MUL_W),
  localparam int LO_W  = MUL_W + SPLIT,
  localparam int HI_W  = 2 * MUL_W - SPLIT
) (
  input  logic [MUL_W-1:0] a,
  input  logic [MUL_W-1:0] b,
  output logic [LO_W-1:0]  pp_lo,
  output logic [HI_W-1:0]  pp_hi
);

  // Two narrower products instead of one full-width multiply
  always_comb begin
    pp_lo = LO_W'(a) * LO_W'(b[SPLIT-1:0]);
    pp_hi = HI_W'(a) * HI_W'(b[MUL_W-1:SPLIT]);
  end

endmodule

// File: rtl/mul_resp.sv
// Fixed-latency pipelined 27x27 mantissa multiplier responder.
// One request per cycle, result LAT cycles later, order kept.
module mul_resp
  import fma_pkg::*;
#(
  parameter int LAT   = 2,
  parameter int MUL_W = fma_pkg::MUL_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [CMD_W-1:0]   req_command,
  input  logic [MUL_W-1:0]   req_in_1,
  input  logic [MUL_W-1:0]   req_in_2,
  output logic [2*MUL_W-1:0] out,
  output logic               out_vld,
  output logic [CMD_W-1:0]   out_command,
  output logic               busy
);

  localparam int PW    = 2 * MUL_W;
  localparam int SPLIT = split_w(MUL_W);
  localparam int LO_W  = MUL_W + SPLIT;
  localparam int HI_W  = 2 * MUL_W - SPLIT;

  logic [LO_W-1:0] pp_lo_c;
  logic [LO_W-1:0] pp_lo_q;
  logic [HI_W-1:0] pp_hi_c;
  logic [HI_W-1:0] pp_hi_q;
  cmd_t            tag1_q;
  logic            vld1_q;
  logic [PW-1:0]   sum_c;

  logic [PW-1:0] sum_d [2:LAT];
  logic [PW-1:0] sum_q [2:LAT];
  cmd_t          tag_d [2:LAT];
  cmd_t          tag_q [2:LAT];
  logic          vld_d [2:LAT];
  logic          vld_q [2:LAT];

  mul_resp_pp #(
    .MUL_W (MUL_W)
  ) u_pp (
    .a     (req_in_1),
    .b     (req_in_2),
    .pp_lo (pp_lo_c),
    .pp_hi (pp_hi_c)
  );

  // Stage 1 valid: follows the request strobe
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) vld1_q <= 1'b0;
    else        vld1_q <= en;
  end

  // Stage 1 data: loads only on a request, idle cycles do not toggle
  always_ff @(posedge clk) begin
    if (en) begin
      pp_lo_q <= pp_lo_c;
      pp_hi_q <= pp_hi_c;
      tag1_q  <= req_command;
    end
  end

  // Recombine the partial products; the exact product fits in PW bits
  always_comb begin
    sum_c = PW'(pp_lo_q) + (PW'(pp_hi_q) << SPLIT);
  end

  assign sum_d[2] = sum_c;
  assign tag_d[2] = tag1_q;
  assign vld_d[2] = vld1_q;

  for (genvar s = 3; s <= LAT; s++) begin : g_link
    assign sum_d[s] = sum_q[s-1];
    assign tag_d[s] = tag_q[s-1];
    assign vld_d[s] = vld_q[s-1];
  end

  for (genvar s = 2; s <= LAT; s++) begin : g_stage
    // Stage s register: data moves only behind a valid, so out holds
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        vld_q[s] <= 1'b0;
        sum_q[s] <= '0;
        tag_q[s] <= '0;
      end else begin
        vld_q[s] <= vld_d[s];
        if (vld_d[s]) begin
          sum_q[s] <= sum_d[s];
          tag_q[s] <= tag_d[s];
        end
      end
    end
  end

  assign out         = sum_q[LAT];
  assign out_command = tag_q[LAT];
  assign out_vld     = vld_q[LAT];

  // Anything in flight anywhere in the pipe
  always_comb begin
    busy = vld1_q;
    for (int s = 2; s <= LAT; s++) begin
      busy = busy | vld_q[s];
    end
  end

endmodule

// File: tb/tb_mul_resp.sv
// Bench for mul_resp at LAT 2, 3 and 4 side by side.
// Reference: per-cycle request history and plain products.
module tb_mul_resp;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic [31:0] cmd = '0;
  logic [26:0] a = '0;
  logic [26:0] b = '0;

  logic [53:0] out_w  [3];
  logic        vld_w  [3];
  logic [31:0] cmd_w  [3];
  logic        busy_w [3];

  int lats [3] = '{2, 3, 4};
  int checks = 0;
  int errors = 0;
  int cyc = 8;

  logic        hist_en [8];
  logic [26:0] hist_a  [8];
  logic [26:0] hist_b  [8];
  logic [31:0] hist_t  [8];
  logic [63:0] exp_out [3];
  logic [31:0] exp_tag [3];

  always #5 clk = ~clk;

  mul_resp #(.LAT(2)) u_lat2 (
    .clk(clk), .reset(reset), .en(en), .req_command(cmd),
    .req_in_1(a), .req_in_2(b), .out(out_w[0]), .out_vld(vld_w[0]),
    .out_command(cmd_w[0]), .busy(busy_w[0])
  );

  mul_resp #(.LAT(3)) u_lat3 (
    .clk(clk), .reset(reset), .en(en), .req_command(cmd),
    .req_in_1(a), .req_in_2(b), .out(out_w[1]), .out_vld(vld_w[1]),
    .out_command(cmd_w[1]), .busy(busy_w[1])
  );

  mul_resp #(.LAT(4)) u_lat4 (
    .clk(clk), .reset(reset), .en(en), .req_command(cmd),
    .req_in_1(a), .req_in_2(b), .out(out_w[2]), .out_vld(vld_w[2]),
    .out_command(cmd_w[2]), .busy(busy_w[2])
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      int   s;
      logic ev;
      logic eb;
      s  = (cyc - lats[i]) & 7;
      ev = hist_en[s];
      if (ev) begin
        exp_out[i] = {37'b0, hist_a[s]} * {37'b0, hist_b[s]};
        exp_tag[i] = hist_t[s];
      end
      eb = 1'b0;
      for (int k = 1; k <= lats[i]; k++) eb = eb | hist_en[(cyc - k) & 7];
      chk($sformatf("lat%0d out_vld", lats[i]), 64'(vld_w[i]), 64'(ev));
      chk($sformatf("lat%0d out", lats[i]), 64'(out_w[i]), exp_out[i]);
      chk($sformatf("lat%0d out_command", lats[i]), 64'(cmd_w[i]),
          64'(exp_tag[i]));
      chk($sformatf("lat%0d busy", lats[i]), 64'(busy_w[i]), 64'(eb));
    end
  endtask

  task automatic step(input logic e, input logic [31:0] t,
                      input logic [26:0] x, input logic [26:0] y);
    en  = e;
    cmd = t;
    a   = x;
    b   = y;
    hist_en[cyc & 7] = e;
    hist_t[cyc & 7]  = t;
    hist_a[cyc & 7]  = x;
    hist_b[cyc & 7]  = y;
    @(posedge clk);
    #1;
    cyc++;
    check_all();
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, $urandom, 27'($urandom), 27'($urandom));
  endtask

  task automatic do_reset();
    en    = 1'b0;
    reset = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst lat%0d out", lats[i]), 64'(out_w[i]), 64'd0);
      chk($sformatf("rst lat%0d out_vld", lats[i]), 64'(vld_w[i]), 64'd0);
      chk($sformatf("rst lat%0d cmd", lats[i]), 64'(cmd_w[i]), 64'd0);
      chk($sformatf("rst lat%0d busy", lats[i]), 64'(busy_w[i]), 64'd0);
      exp_out[i] = '0;
      exp_tag[i] = '0;
    end
    for (int k = 0; k < 8; k++) hist_en[k] = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  function automatic logic [26:0] pick();
    case ($urandom_range(0, 9))
      0:       return 27'h0;
      1:       return 27'h7FFFFFF;
      2:       return 27'h4000000;
      default: return 27'($urandom);
    endcase
  endfunction

  initial begin
    int nb;
    for (int k = 0; k < 8; k++) begin
      hist_en[k] = 1'b0;
      hist_a[k]  = '0;
      hist_b[k]  = '0;
      hist_t[k]  = '0;
    end
    for (int i = 0; i < 3; i++) begin
      exp_out[i] = '0;
      exp_tag[i] = '0;
    end

    #1;
    for (int i = 0; i < 3; i++) begin
      chk("init out", 64'(out_w[i]), 64'd0);
      chk("init out_vld", 64'(vld_w[i]), 64'd0);
      chk("init busy", 64'(busy_w[i]), 64'd0);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;

    idle(1);
    step(1'b1, 32'd100, 27'h7FFFFFF, 27'h7FFFFFF);
    idle(1);
    chk("t1 out", 64'(out_w[0]), 64'h3FFFFFF0000001);
    chk("t1 vld", 64'(vld_w[0]), 64'd1);
    idle(1);
    chk("t1 vld drop", 64'(vld_w[0]), 64'd0);

    idle(4);
    step(1'b1, 32'd1, 27'd3, 27'd5);
    step(1'b1, 32'd2, 27'd0, 27'h7FFFFFF);
    chk("t2 out a", 64'(out_w[0]), 64'd15);
    chk("t2 tag a", 64'(cmd_w[0]), 64'd1);
    step(1'b1, 32'd3, 27'h4000000, 27'd2);
    chk("t2 out b", 64'(out_w[0]), 64'd0);
    chk("t2 tag b", 64'(cmd_w[0]), 64'd2);
    idle(1);
    chk("t2 out c", 64'(out_w[0]), 64'h8000000);
    chk("t2 tag c", 64'(cmd_w[0]), 64'd3);

    idle(4);
    step(1'b1, 32'(-7), 27'h1234, 27'h10);
    idle(1);
    chk("t3 out", 64'(out_w[0]), 64'h12340);
    chk("t3 tag", 64'(cmd_w[0]), 64'hFFFFFFF9);
    idle(5);
    chk("t3 out hold", 64'(out_w[0]), 64'h12340);
    chk("t3 tag hold", 64'(cmd_w[0]), 64'hFFFFFFF9);
    chk("t3 vld idle", 64'(vld_w[0]), 64'd0);

    idle(4);
    step(1'b1, 32'd40, 27'd11, 27'd13);
    step(1'b1, 32'd41, 27'd17, 27'd19);
    do_reset();
    idle(6);
    step(1'b1, 32'd42, 27'd23, 27'd29);
    step(1'b1, 32'd43, 27'd31, 27'd37);
    do_reset();
    step(1'b1, 32'd44, 27'h7FFFFFF, 27'd3);
    idle(6);

    idle(2);
    step(1'b1, 32'd55, 27'h5A5A5A5, 27'h2B3C4D1);
    nb = int'(busy_w[2]);
    repeat (3) begin
      idle(1);
      nb += int'(busy_w[2]);
    end
    chk("t5 out", 64'(out_w[2]), 64'h5A5A5A5 * 64'h2B3C4D1);
    chk("t5 vld", 64'(vld_w[2]), 64'd1);
    repeat (3) begin
      idle(1);
      nb += int'(busy_w[2]);
    end
    chk("t5 busy cycles", 64'(nb), 64'd4);

    for (int blk = 0; blk < 20; blk++) begin
      int duty;
      duty = $urandom_range(10, 100);
      for (int j = 0; j < 500; j++) begin
        step($urandom_range(1, 100) <= duty, $urandom, pick(), pick());
      end
      if (blk == 7 || blk == 14) do_reset();
    end
    idle(6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
